seq_det_sched: RTL
==================

Name: seq_det_sched

Overview:
- Scheduler and controller for the shared serial sequence detector (`seq_detector`: clk, reset, seq_in, seq_detected).
- Accepts parallel words on a valid/ready input and serialises each word MSB-first into the detector. Optionally flushes detector history first.
- Collects the detector's hit pulses, attributes each to a bit position, and returns a per-word result on a valid/ready output.
- Sits between the word source and the detector instance. The detector wrapper gates state updates with det_en.

Parameters:
- WIDTH, 8, bits per word; power of two, 4..16.
- POS_W, 3, bit-position width; 2**POS_W == WIDTH.
- CNT_W, 4, hit-counter width; saturating.
- DET_LAT, 1, cycles from bit driven on det_seq_in to its hit visible on det_hit; 1..3.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush_en  in  1  1 = pulse det_flush before each word; sampled at input accept.
- in_valid  in  1  input word valid.
- in_data  in  WIDTH  word to scan.
- in_ready  out  1  scheduler can accept a word.
- det_seq_in  out  1  serial bit to detector.
- det_en  out  1  detector state-update enable; high only for valid bit cycles.
- det_flush  out  1  one-cycle detector clear (active-high; wrapper maps to detector reset).
- det_hit  in  1  detector seq_detected.
- out_valid  out  1  result valid.
- out_found  out  1  at least one hit in word.
- out_count  out  CNT_W  hits in word, saturating at 2**CNT_W-1.
- out_first_pos  out  POS_W  bit index (0 = MSB, first shifted) of first hit; 0 when out_found=0.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Reset (reset==0 at clk edge) is synchronous and overrides everything, including mid-word and mid-report operation.
  - State goes to IDLE.
  - Outputs in_ready=0 during reset, then 1 in IDLE.
  - det_seq_in=0, det_en=0, det_flush=0, out_valid=0, out_found=0, out_count=0, out_first_pos=0.
  - Partial word is discarded.
- FSM states: IDLE, FLUSH, SHIFT, DRAIN, REPORT.
- in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On in_valid&&in_ready, latch in_data and flush_en, clear count/found/pos, bit_idx=0.
  - Next state is FLUSH if flush_en=1, else SHIFT.
- FLUSH: exactly 1 cycle with det_flush=1, det_en=0, det_seq_in=0; then SHIFT.
- SHIFT:
  - WIDTH cycles. Cycle i drives det_seq_in=word[WIDTH-1-i] and det_en=1.
  - After cycle WIDTH-1, go to DRAIN.
- DRAIN: DET_LAT cycles with det_en=0 and det_seq_in=0; then REPORT.
- Hit sampling:
  - det_hit is sampled exactly WIDTH times, in the cycle DET_LAT cycles after each SHIFT cycle i. That sample is attributed to bit index i.
  - Sampling windows span the SHIFT and DRAIN states.
  - det_hit outside these windows is ignored.
- On a sampled hit:
  - count increments, holding at 2**CNT_W-1.
  - If found==0, set found=1 and first_pos=i.
- REPORT:
  - out_valid=1; out_* are stable until out_valid&&out_ready.
  - On handshake, the next state is IDLE and out_valid drops next cycle.
  - in_valid is ignored in REPORT.
- det_flush and det_en are never high in the same cycle.
- det_en=0 in IDLE and REPORT, so detector history is preserved across words when flush_en=0.
- Minimum word period: WIDTH + DET_LAT + 2 cycles (+1 with flush). There is no pipelining of the next word.
- in_data changes while not accepted have no effect. The word is captured once at accept.

Test Plan:
- Bench detector model: overlapping "1011" detector, Moore, DET_LAT=1, gated by det_en, cleared by det_flush.
- Reset 3 cycles, flush_en=1, word 8'b1011_0110 -> after 11 cycles out_valid=1, out_found=1, out_count=2, out_first_pos=3.
- Word 8'b1011_1011 (flush_en=1) -> out_count=2, out_first_pos=3; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
- Word 8'h00 -> out_found=0, out_count=0, out_first_pos=0; det_en high exactly 8 cycles.
- Cross-word history:
  - flush_en=0: word 8'h05 -> count 0; then word 8'h80 -> count 1, first_pos=0.
  - Repeat with flush_en=1 -> second word count 0, and det_flush pulses once before each SHIFT.
- Reset asserted in SHIFT at bit 4 -> next cycle all outputs 0 and in_ready=1 after release; next word 8'b1011_0110 reports count 2 with no stale hits.

Source files
------------

// File: rtl/seq_det_sched.sv
// Word scheduler for the shared serial sequence detector: serialises words
// MSB-first, attributes detector hits to bit positions and reports per word.
module seq_det_sched #(
    parameter int WIDTH   = 8,
    parameter int POS_W   = 3,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             det_seq_in,
    output logic             det_en,
    output logic             det_flush,
    input  logic             det_hit,
    output logic             out_valid,
    output logic             out_found,
    output logic [CNT_W-1:0] out_count,
    output logic [POS_W-1:0] out_first_pos,
    input  logic             out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SHIFT,
        DRAIN,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WIDTH - 1);
    localparam logic [1:0]       LAST_DRN = 2'(DET_LAT - 1);

    state_t             state;
    logic [WIDTH-1:0]   word;
    logic [POS_W-1:0]   bit_idx;
    logic [POS_W-1:0]   samp_idx;
    logic [1:0]         drain_cnt;
    logic [DET_LAT-1:0] en_pipe;
    logic               samp;

    assign in_ready = reset && (state == IDLE);

    // det_en delayed by DET_LAT marks the cycle whose det_hit belongs to a bit
    assign samp = en_pipe[DET_LAT-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            word          <= '0;
            bit_idx       <= '0;
            samp_idx      <= '0;
            drain_cnt     <= '0;
            en_pipe       <= '0;
            det_seq_in    <= 1'b0;
            det_en        <= 1'b0;
            det_flush     <= 1'b0;
            out_valid     <= 1'b0;
            out_found     <= 1'b0;
            out_count     <= '0;
            out_first_pos <= '0;
        end else begin
            en_pipe <= DET_LAT'({en_pipe, det_en});

            if (samp) begin
                samp_idx <= samp_idx + 1'b1;
                if (det_hit) begin
                    if (out_count != CNT_MAX)
                        out_count <= out_count + 1'b1;
                    if (!out_found) begin
                        out_found     <= 1'b1;
                        out_first_pos <= samp_idx;
                    end
                end
            end

            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        word          <= in_data;
                        bit_idx       <= '0;
                        samp_idx      <= '0;
                        out_found     <= 1'b0;
                        out_count     <= '0;
                        out_first_pos <= '0;
                        if (flush_en) begin
                            det_flush <= 1'b1;
                            state     <= FLUSH;
                        end else begin
                            det_en     <= 1'b1;
                            det_seq_in <= in_data[WIDTH-1];
                            state      <= SHIFT;
                        end
                    end
                end
                FLUSH: begin
                    det_flush  <= 1'b0;
                    det_en     <= 1'b1;
                    det_seq_in <= word[WIDTH-1];
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (bit_idx == LAST_BIT) begin
                        det_en     <= 1'b0;
                        det_seq_in <= 1'b0;
                        drain_cnt  <= '0;
                        state      <= DRAIN;
                    end else begin
                        bit_idx    <= bit_idx + 1'b1;
                        word       <= word << 1;
                        det_seq_in <= word[WIDTH-2];
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRN) begin
                        out_valid <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
